// File: rtl/tlc_line_sched_pkg.sv
// Shared constants and types for the TLC5957 line scheduler.
//   WORD_W          width of one packed greyscale word
//   BYTES_PER_WORD  FIFO bytes packed into one word
//   SH_CMD_*        shifter command encodings (3 is reserved, never driven)
//   sched_state_e   scheduler FSM states
package tlc_line_sched_pkg;

  localparam int unsigned WORD_W         = 48;
  localparam int unsigned BYTES_PER_WORD = 6;

  localparam logic [1:0] SH_CMD_SHIFT = 2'd0;
  localparam logic [1:0] SH_CMD_WRTGS = 2'd1;
  localparam logic [1:0] SH_CMD_LATGS = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StPresent = 2'd2
  } sched_state_e;

  // Command for a word: LATGS closes the line, WRTGS closes each pass through the chain.
  // With a single chip there is no chain boundary to mark, so only LATGS is special.
  function automatic logic [1:0] word_cmd(input logic last_word, input logic last_chip,
                                          input logic multi_chip);
    if (last_word) return SH_CMD_LATGS;
    if (multi_chip && last_chip) return SH_CMD_WRTGS;
    return SH_CMD_SHIFT;
  endfunction

endpackage

// File: rtl/tlc_line_sched_if.sv
// Handshake bundle between the scheduler, the colour FIFO and the serial shifter.
//   fifo_rd/fifo_data/fifo_empty  FIFO read port (data one cycle after fifo_rd)
//   sh_valid/sh_ready/sh_data/sh_cmd  word stream to the shifter
// Modports: master = scheduler side, slave = FIFO/shifter side.
interface tlc_line_sched_if;
  import tlc_line_sched_pkg::*;

  logic              fifo_rd;
  logic [7:0]        fifo_data;
  logic              fifo_empty;
  logic              sh_valid;
  logic              sh_ready;
  logic [WORD_W-1:0] sh_data;
  logic [1:0]        sh_cmd;

  modport master (
    output fifo_rd, sh_valid, sh_data, sh_cmd,
    input  fifo_data, fifo_empty, sh_ready
  );

  modport slave (
    input  fifo_rd, sh_valid, sh_data, sh_cmd,
    output fifo_data, fifo_empty, sh_ready
  );
endinterface

// File: rtl/tlc_line_sched_packer.sv
// tlc_byte_packer: shifts FIFO bytes into a 48-bit word, first byte ending in [47:40].
//   sys_clk, global_rst  clock, synchronous active-high reset
//   clear                drop the current word and byte count
//   load, byte_in        append one byte
//   word                 packed word
//   done                 high while the final byte of a word is being loaded
module tlc_byte_packer
  import tlc_line_sched_pkg::*;
(
  input  logic              sys_clk,
  input  logic              global_rst,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              done
);

  logic [WORD_W-1:0] word_q;
  logic [2:0]        cnt_q;

  always_ff @(posedge sys_clk) begin
    if (global_rst || clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      word_q <= {word_q[WORD_W-9:0], byte_in};
      cnt_q  <= cnt_q + 3'd1;
    end
  end

  assign word = word_q;
  assign done = load && (cnt_q == 3'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/tlc_line_sched.sv
// tlc_line_sched: per-line scheduler between the colour FIFO and the TLC5957 shifter.
// Each accepted line_sync drains CHIPS*GRP_WORDS words of 6 bytes from the FIFO and issues
// them with SHIFT/WRTGS/LATGS; tracks the angular line index and flags underrun/overrun.
// Ports:
//   sys_clk, global_rst   clock, synchronous active-high reset
//   frame_start           pulse: next accepted line_sync restarts line_idx at 0
//   line_sync             pulse: start of a new angular line
//   bus (master)          FIFO read port and shifter word stream
//   line_idx              index of line currently/last scheduled
//   busy                  line in progress
//   underrun, overrun     1-cycle pulses: FIFO empty at line start / line_sync while busy
// Build option: BLANK_ON_UNDERRUN_EN -- an underrun line is sent as all-zero words instead
// of being skipped.
module tlc_line_sched
  import tlc_line_sched_pkg::*;
#(
  parameter int unsigned LINES     = 512,
  parameter int unsigned CHIPS     = 1,
  parameter int unsigned GRP_WORDS = 16
) (
  input  logic                     sys_clk,
  input  logic                     global_rst,
  input  logic                     frame_start,
  input  logic                     line_sync,
  tlc_line_sched_if.master         bus,
  output logic [$clog2(LINES)-1:0] line_idx,
  output logic                     busy,
  output logic                     underrun,
  output logic                     overrun
);

  localparam int unsigned NWords   = CHIPS * GRP_WORDS;
  localparam int unsigned WordCntW = $clog2(NWords + 1);
  localparam int unsigned ChipW    = $clog2(CHIPS + 1);
  localparam int unsigned IdxW     = $clog2(LINES);
  localparam bit          MultiChip = (CHIPS > 1);

  sched_state_e        state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                pend_q, pend_d;
  logic                busy_q, busy_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;
  logic                blank_q, blank_d;
  logic [2:0]          rd_cnt_q, rd_cnt_d;
  logic                rd_pend_q;
  logic [WordCntW-1:0] word_q, word_d;
  logic [ChipW-1:0]    chip_q, chip_d;

  logic              fifo_rd;
  logic              pk_clear;
  logic              pk_done;
  logic [WORD_W-1:0] pk_word;
  logic              last_word;
  logic              last_chip;
  logic              present;

  tlc_byte_packer u_packer (
    .sys_clk    (sys_clk),
    .global_rst (global_rst),
    .clear      (pk_clear),
    .load       (rd_pend_q),
    .byte_in    (bus.fifo_data),
    .word       (pk_word),
    .done       (pk_done)
  );

  assign last_word = (word_q == WordCntW'(NWords - 1));
  assign last_chip = (chip_q == ChipW'(CHIPS - 1));
  assign present   = (state_q == StPresent);

  // Gated by reset so an aborted line issues no read in the reset cycle itself.
  assign fifo_rd = (state_q == StFetch) && !blank_q && !bus.fifo_empty &&
                   (rd_cnt_q < 3'(BYTES_PER_WORD)) && !global_rst;

  assign bus.fifo_rd  = fifo_rd;
  assign bus.sh_valid = present;
  assign bus.sh_data  = (present && !blank_q) ? pk_word : '0;
  assign bus.sh_cmd   = present ? word_cmd(last_word, last_chip, MultiChip) : SH_CMD_SHIFT;

  assign line_idx = idx_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q | frame_start;
    busy_d     = busy_q;
    underrun_d = 1'b0;
    overrun_d  = line_sync && (state_q != StIdle);
    blank_d    = blank_q;
    rd_cnt_d   = rd_cnt_q + {2'b00, fifo_rd};
    word_d     = word_q;
    chip_d     = chip_q;
    pk_clear   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (line_sync) begin
          // Skipped lines still advance the index.
          if (pend_q || frame_start) idx_d = '0;
          else if (idx_q == IdxW'(LINES - 1)) idx_d = '0;
          else idx_d = idx_q + IdxW'(1);
          pend_d = 1'b0;
          if (bus.fifo_empty) begin
            underrun_d = 1'b1;
`ifdef BLANK_ON_UNDERRUN_EN
            blank_d = 1'b1;
            busy_d  = 1'b1;
            state_d = StFetch;
`endif
          end else begin
            blank_d = 1'b0;
            busy_d  = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (blank_q || pk_done) state_d = StPresent;
      end
      StPresent: begin
        if (bus.sh_ready) begin
          pk_clear = 1'b1;
          rd_cnt_d = '0;
          if (last_word) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            blank_d = 1'b0;
            word_d  = '0;
            chip_d  = '0;
          end else begin
            state_d = StFetch;
            word_d  = word_q + WordCntW'(1);
            chip_d  = last_chip ? '0 : chip_q + ChipW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (global_rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      blank_q    <= 1'b0;
      rd_cnt_q   <= '0;
      rd_pend_q  <= 1'b0;
      word_q     <= '0;
      chip_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      blank_q    <= blank_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_pend_q  <= fifo_rd;
      word_q     <= word_d;
      chip_q     <= chip_d;
    end
  end

endmodule

// File: tb/tb_tlc_line_sched.sv
module tb_tlc_line_sched;

  logic       sys_clk = 1'b0;
  logic       global_rst, frame_start, line_sync;
  logic [8:0] line_idx;
  logic       busy, underrun, overrun;
  logic       line_sync2;
  logic       frame_start2 = 1'b0;
  logic [8:0] line_idx2;
  logic       busy2, underrun2, overrun2;

  always #5 sys_clk = ~sys_clk;

  tlc_line_sched_if bus ();
  tlc_line_sched_if bus2 ();

  tlc_line_sched #(.LINES(512), .CHIPS(1), .GRP_WORDS(16)) dut (
    .sys_clk     (sys_clk),
    .global_rst  (global_rst),
    .frame_start (frame_start),
    .line_sync   (line_sync),
    .bus         (bus),
    .line_idx    (line_idx),
    .busy        (busy),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  tlc_line_sched #(.LINES(512), .CHIPS(2), .GRP_WORDS(16)) dut2 (
    .sys_clk     (sys_clk),
    .global_rst  (global_rst),
    .frame_start (frame_start2),
    .line_sync   (line_sync2),
    .bus         (bus2),
    .line_idx    (line_idx2),
    .busy        (busy2),
    .underrun    (underrun2),
    .overrun     (overrun2)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // FIFO model for dut: byte array with pointers, one-cycle read latency.
  logic [7:0] mem [0:511];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       force_empty = 1'b0;
  assign bus.fifo_empty = force_empty || (wr_ptr == rd_ptr);
  always @(posedge sys_clk)
    if (bus.fifo_rd && !bus.fifo_empty) begin
      bus.fifo_data <= mem[rd_ptr % 512];
      rd_ptr        <= rd_ptr + 1;
    end

  // FIFO model for dut2: returns 0,1,2,... up to avail2 bytes.
  int avail2 = 0;
  int cnt2   = 0;
  assign bus2.fifo_empty = (cnt2 >= avail2);
  always @(posedge sys_clk)
    if (bus2.fifo_rd && !bus2.fifo_empty) begin
      bus2.fifo_data <= 8'(cnt2);
      cnt2           <= cnt2 + 1;
    end

  // Pulse/strobe counters sampled mid-cycle.
  int rd_pulses = 0, viol = 0, viol2 = 0, ur_pulses = 0, ov_pulses = 0;
  always @(negedge sys_clk) begin
    if (bus.fifo_rd) rd_pulses <= rd_pulses + 1;
    if (bus.fifo_rd && bus.fifo_empty) viol <= viol + 1;
    if (bus2.fifo_rd && bus2.fifo_empty) viol2 <= viol2 + 1;
    if (underrun) ur_pulses <= ur_pulses + 1;
    if (overrun) ov_pulses <= ov_pulses + 1;
  end

  // Scoreboards.
  logic [47:0] exp_data[$];
  logic [1:0]  exp_cmd[$];
  logic [47:0] exp_data2[$];
  logic [1:0]  exp_cmd2[$];

  always @(negedge sys_clk)
    if (bus.sh_valid && bus.sh_ready) begin
      if (exp_data.size() == 0) begin
        n_total++;
        $display("FAIL sb1_unexpected: got word %h cmd %0d, required none", bus.sh_data,
                 bus.sh_cmd);
      end else begin
        check("sb1_data", 64'(bus.sh_data), 64'(exp_data.pop_front()));
        check("sb1_cmd", 64'(bus.sh_cmd), 64'(exp_cmd.pop_front()));
        check("sb1_busy", 64'(busy), 64'd1);
      end
    end

  always @(negedge sys_clk)
    if (bus2.sh_valid && bus2.sh_ready) begin
      if (exp_data2.size() == 0) begin
        n_total++;
        $display("FAIL sb2_unexpected: got word %h cmd %0d, required none", bus2.sh_data,
                 bus2.sh_cmd);
      end else begin
        check("sb2_data", 64'(bus2.sh_data), 64'(exp_data2.pop_front()));
        check("sb2_cmd", 64'(bus2.sh_cmd), 64'(exp_cmd2.pop_front()));
      end
    end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_ls();
    line_sync = 1'b1;
    tick();
    line_sync = 1'b0;
  endtask

  task automatic preload(input int base, input int n);
    for (int i = 0; i < n; i++) mem[(wr_ptr + i) % 512] = 8'(base + i);
    wr_ptr = wr_ptr + n;
  endtask

  // 16 single-chip words built from consecutive bytes starting at base.
  task automatic push_words(input int base, input bit blank);
    logic [47:0] d;
    for (int k = 0; k < 16; k++) begin
      d = '0;
      for (int j = 0; j < 6; j++) d = {d[39:0], 8'(base + 6 * k + j)};
      exp_data.push_back(blank ? 48'd0 : d);
      exp_cmd.push_back(k == 15 ? 2'd2 : 2'd0);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    int r0, u0, o0, k, mism;
    logic [47:0] d;

    global_rst = 1'b1;
    frame_start = 1'b0;
    line_sync = 1'b0;
    line_sync2 = 1'b0;
    bus.sh_ready = 1'b0;
    bus2.sh_ready = 1'b1;
    tick(3);
    check("rst_sh_valid", 64'(bus.sh_valid), 64'd0);
    check("rst_fifo_rd", 64'(bus.fifo_rd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_line_idx", 64'(line_idx), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_sh_data", 64'(bus.sh_data), 64'd0);
    global_rst = 1'b0;
    tick();

    // T1: one full line, single chip.
    preload(0, 96);
    push_words(0, 1'b0);
    bus.sh_ready = 1'b1;
    r0 = rd_pulses;
    pulse_ls();
    wait_idle("t1_done", 400);
    tick();
    check("t1_line_idx", 64'(line_idx), 64'd1);
    check("t1_reads", 64'(rd_pulses - r0), 64'd96);
    check("t1_sb_drained", 64'(exp_data.size()), 64'd0);

    // T2: two-chip chain, 32 words alternating SHIFT/WRTGS, final LATGS.
    for (int n = 0; n < 32; n++) begin
      d = '0;
      for (int j = 0; j < 6; j++) d = {d[39:0], 8'(6 * n + j)};
      exp_data2.push_back(d);
      exp_cmd2.push_back(n == 31 ? 2'd2 : (n % 2 == 1 ? 2'd1 : 2'd0));
    end
    avail2 = 192;
    line_sync2 = 1'b1;
    tick();
    line_sync2 = 1'b0;
    k = 0;
    while (busy2 && k < 800) begin
      tick();
      k++;
    end
    check("t2_done", 64'(busy2), 64'd0);
    tick();
    check("t2_reads", 64'(cnt2), 64'd192);
    check("t2_line_idx", 64'(line_idx2), 64'd1);
    check("t2_sb_drained", 64'(exp_data2.size()), 64'd0);

    // T3: FIFO empty at line start.
    u0 = ur_pulses;
    r0 = rd_pulses;
`ifdef BLANK_ON_UNDERRUN_EN
    push_words(0, 1'b1);
    pulse_ls();
    wait_idle("t3_blank_done", 400);
`else
    pulse_ls();
    tick(2);
    check("t3_busy", 64'(busy), 64'd0);
`endif
    tick();
    check("t3_underrun", 64'(ur_pulses - u0), 64'd1);
    check("t3_reads", 64'(rd_pulses - r0), 64'd0);
    check("t3_line_idx", 64'(line_idx), 64'd2);

    // T4: line_sync ~20 cycles into a line.
    preload(8'h60, 96);
    push_words(8'h60, 1'b0);
    o0 = ov_pulses;
    r0 = rd_pulses;
    pulse_ls();
    tick(19);
    pulse_ls();
    wait_idle("t4_done", 400);
    tick();
    check("t4_overrun", 64'(ov_pulses - o0), 64'd1);
    check("t4_line_idx", 64'(line_idx), 64'd3);
    check("t4_reads", 64'(rd_pulses - r0), 64'd96);
    check("t4_sb_drained", 64'(exp_data.size()), 64'd0);

    // T5: backpressure on word 3, FIFO stall during word 4.
    bus.sh_ready = 1'b0;
    preload(8'hC0, 96);
    push_words(8'hC0, 1'b0);
    pulse_ls();
    for (int w = 0; w < 16; w++) begin
      k = 0;
      while (!bus.sh_valid && k < 100) begin
        tick();
        k++;
      end
      check("t5_valid", 64'(bus.sh_valid), 64'd1);
      if (w == 3) begin
        r0 = rd_pulses;
        mism = 0;
        repeat (50) begin
          tick();
          if (!bus.sh_valid || bus.sh_data !== 48'hD2D3D4D5D6D7 || bus.sh_cmd !== 2'd0)
            mism++;
        end
        check("t5_hold_mismatches", 64'(mism), 64'd0);
        check("t5_hold_reads", 64'(rd_pulses - r0), 64'd0);
      end
      bus.sh_ready = 1'b1;
      tick();
      bus.sh_ready = 1'b0;
      if (w == 3) begin
        tick(2);
        force_empty = 1'b1;
        r0 = rd_pulses;
        tick(10);
        check("t5_stall_reads", 64'(rd_pulses - r0), 64'd0);
        force_empty = 1'b0;
      end
    end
    wait_idle("t5_done", 50);
    check("t5_line_idx", 64'(line_idx), 64'd4);
    check("t5_sb_drained", 64'(exp_data.size()), 64'd0);

`ifndef BLANK_ON_UNDERRUN_EN
    // T6: index wrap and frame restart via skipped (empty-FIFO) lines.
    repeat (507) pulse_ls();
    check("t6_idx_511", 64'(line_idx), 64'd511);
    pulse_ls();
    check("t6_wrap", 64'(line_idx), 64'd0);
    repeat (200) pulse_ls();
    check("t6_idx_200", 64'(line_idx), 64'd200);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t6_pend_hold", 64'(line_idx), 64'd200);
    pulse_ls();
    check("t6_frame_zero", 64'(line_idx), 64'd0);
    pulse_ls();
    check("t6_pend_cleared", 64'(line_idx), 64'd1);
    frame_start = 1'b1;
    pulse_ls();
    frame_start = 1'b0;
    check("t6_same_cycle", 64'(line_idx), 64'd0);
    tick();
`endif

    // T6: reset mid-line.
    preload(8'h10, 96);
    bus.sh_ready = 1'b1;
    pulse_ls();
    tick(3);
    global_rst = 1'b1;
    tick();
    check("t6_rst_fifo_rd", 64'(bus.fifo_rd), 64'd0);
    check("t6_rst_sh_valid", 64'(bus.sh_valid), 64'd0);
    check("t6_rst_sh_data", 64'(bus.sh_data), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_line_idx", 64'(line_idx), 64'd0);
    r0 = rd_pulses;
    tick(3);
    global_rst = 1'b0;
    tick(10);
    check("t6_rst_no_reads", 64'(rd_pulses - r0), 64'd0);
    check("t6_rst_no_words", 64'(bus.sh_valid), 64'd0);

    check("sb1_leftover", 64'(exp_data.size()), 64'd0);
    check("fifo_rd_while_empty", 64'(viol), 64'd0);
    check("fifo_rd_while_empty2", 64'(viol2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
